// File: rtl/muldiv_pkg.sv
// Shared types and op decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OpMulS = 2'b00,
        OpDivS = 2'b01,
        OpMulU = 2'b10,
        OpDivU = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } muldiv_state_t;

    localparam int unsigned OpDivBit = 0;
    localparam int unsigned OpUnsBit = 1;

    function automatic logic op_is_div(input muldiv_op_t op);
        logic [1:0] enc;
        enc = op;
        return enc[OpDivBit];
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        logic [1:0] enc;
        enc = op;
        return ~enc[OpUnsBit];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Two's-complement sign fixer: negates two WIDTH-bit values independently, or the
// concatenated {val_hi, val_lo} as one 2*WIDTH-bit value when pair is set.
module muldiv_sign_fix #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] val_lo,
    input  logic [WIDTH-1:0] val_hi,
    input  logic             neg_lo,
    input  logic             neg_hi,
    input  logic             pair,
    output logic [WIDTH-1:0] fix_lo,
    output logic [WIDTH-1:0] fix_hi
);

    logic [2*WIDTH-1:0] pair_neg;

    always_comb begin
        pair_neg = -{val_hi, val_lo};
        fix_lo   = neg_lo ? -val_lo : val_lo;
        fix_hi   = neg_hi ? -val_hi : val_hi;
        // In pair mode neg_lo carries the sign of the whole double-width value.
        if (pair && neg_lo) begin
            {fix_hi, fix_lo} = pair_neg;
        end
    end

endmodule

// File: rtl/pipe_muldiv_unit.sv
// Radix-2 iterative signed/unsigned multiply-divide unit with pipeline stall.
// Optional MULDIV_DIVZERO_EN adds the dz port and a single-cycle divide-by-zero path.
module pipe_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
`ifdef MULDIV_DIVZERO_EN
    ,
    output logic             dz
`endif
);

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q;
    logic [WIDTH-1:0] opd_q, acc_q, lo_q, res_lo_q, res_hi_q;
    logic [CNT_W-1:0] count_q;
    logic             neg_lo_q, neg_hi_q;

    muldiv_op_t       issue_op;
    logic             issue, issue_div, issue_sgn, sign_a, sign_b, b_zero, dz_fast;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_lo, step_hi, res_lo_d, res_hi_d;
    logic [WIDTH:0]   sum, shifted, diff;
    logic             qbit;

    assign issue_op  = muldiv_op_t'(op);
    assign issue_div = op_is_div(issue_op);
    assign issue_sgn = op_is_signed(issue_op);
    assign sign_a    = issue_sgn & op_a[WIDTH-1];
    assign sign_b    = issue_sgn & op_b[WIDTH-1];
    assign b_zero    = (op_b == '0);
    assign issue     = start & ~flush & (state_q != StRun);

`ifdef MULDIV_DIVZERO_EN
    assign dz_fast = issue & issue_div & b_zero;
`else
    assign dz_fast = 1'b0;
`endif

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_in (
        .val_lo (op_a),
        .val_hi (op_b),
        .neg_lo (sign_a),
        .neg_hi (sign_b),
        .pair   (1'b0),
        .fix_lo (mag_a),
        .fix_hi (mag_b)
    );

    // One iteration: shift-add for MUL, restoring shift-subtract for DIV.
    always_comb begin
        sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        shifted = {acc_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, opd_q};
        qbit    = ~diff[WIDTH];
        if (op_is_div(op_q)) begin
            step_hi = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], qbit};
        end else begin
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_out (
        .val_lo (step_lo),
        .val_hi (step_hi),
        .neg_lo (neg_lo_q),
        .neg_hi (neg_hi_q),
        .pair   (~op_is_div(op_q)),
        .fix_lo (res_lo_d),
        .fix_hi (res_hi_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (issue) begin
                    state_d = dz_fast ? StDone : StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (count_q == CNT_W'(1)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= OpMulS;
            opd_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            count_q  <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                op_q    <= issue_op;
                acc_q   <= '0;
                count_q <= CNT_W'(WIDTH);
                if (issue_div) begin
                    opd_q    <= mag_b;
                    lo_q     <= mag_a;
                    // A zero divisor keeps the quotient at its natural all-ones value.
                    neg_lo_q <= (sign_a ^ sign_b) & ~b_zero;
                    neg_hi_q <= sign_a;
                end else begin
                    opd_q    <= mag_a;
                    lo_q     <= mag_b;
                    neg_lo_q <= sign_a ^ sign_b;
                    neg_hi_q <= 1'b0;
                end
            end else if (state_q == StRun) begin
                acc_q   <= step_hi;
                lo_q    <= step_lo;
                count_q <= count_q - CNT_W'(1);
            end
            if (state_q == StRun && state_d == StDone) begin
                res_lo_q <= res_lo_d;
                res_hi_q <= res_hi_d;
            end else if (dz_fast) begin
                res_lo_q <= '1;
                res_hi_q <= op_a;
            end
        end
    end

`ifdef MULDIV_DIVZERO_EN
    logic dz_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz_fast;
        end
    end

    assign dz = dz_q;
`endif

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign stall     = (start & ~flush & (state_q == StIdle)) | busy;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;

endmodule

// File: tb/tb_pipe_muldiv_unit.sv
// Directed-vector bench for pipe_muldiv_unit at WIDTH=16; honours MULDIV_DIVZERO_EN.
module tb_pipe_muldiv_unit;

    localparam int unsigned WIDTH = 16;

`ifdef MULDIV_DIVZERO_EN
    localparam int DzLat = 1;
`else
    localparam int DzLat = 17;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic             flush;
    logic [WIDTH-1:0] op_a, op_b;
    logic             busy, stall, done;
    logic [WIDTH-1:0] result_lo, result_hi;
`ifdef MULDIV_DIVZERO_EN
    logic             dz;
`endif

    int n_vec = 0;
    int n_err = 0;

    pipe_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .flush     (flush),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi)
`ifdef MULDIV_DIVZERO_EN
        ,
        .dz        (dz)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from the current cycle and return in the done cycle (or after 40 cycles).
    task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int stalls);
        op    = o;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        #1;
        stalls = stall ? 1 : 0;
        step();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            if (stall) stalls++;
            step();
            lat++;
        end
    endtask

    task automatic check_dz(input string tag, input logic exp);
`ifdef MULDIV_DIVZERO_EN
        check(tag, {31'd0, dz}, {31'd0, exp});
`endif
    endtask

    initial begin
        int lat, stalls, seen;
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        op_a  = '0;
        op_b  = '0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_lo", {16'd0, result_lo}, 32'd0);
        check("rst_hi", {16'd0, result_hi}, 32'd0);
        check_dz("rst_dz", 1'b0);
        reset = 1'b0;
        step();

        // Signed multiply 7 * -3 = -21
        do_op(2'b00, 16'h0007, 16'hFFFD, lat, stalls);
        check("muls_lat", lat, 17);
        check("muls_stall", stalls, 17);
        check("muls_lo", {16'd0, result_lo}, 32'h0000FFEB);
        check("muls_hi", {16'd0, result_hi}, 32'h0000FFFF);
        step();
        check("muls_pulse", {31'd0, done}, 32'd0);
        check("muls_hold_lo", {16'd0, result_lo}, 32'h0000FFEB);

        // Unsigned multiply max * max
        do_op(2'b10, 16'hFFFF, 16'hFFFF, lat, stalls);
        check("mulu_lo", {16'd0, result_lo}, 32'h00000001);
        check("mulu_hi", {16'd0, result_hi}, 32'h0000FFFE);
        step();

        // Unsigned divide 100 / 7
        do_op(2'b11, 16'd100, 16'd7, lat, stalls);
        check("divu_lat", lat, 17);
        check("divu_lo", {16'd0, result_lo}, 32'h0000000E);
        check("divu_hi", {16'd0, result_hi}, 32'h00000002);
        step();

        // Signed divide -7 / 2 = -3 rem -1
        do_op(2'b01, 16'hFFF9, 16'h0002, lat, stalls);
        check("divs_lo", {16'd0, result_lo}, 32'h0000FFFD);
        check("divs_hi", {16'd0, result_hi}, 32'h0000FFFF);
        step();

        // Signed overflow -32768 / -1
        do_op(2'b01, 16'h8000, 16'hFFFF, lat, stalls);
        check("ovf_lat", lat, 17);
        check("ovf_lo", {16'd0, result_lo}, 32'h00008000);
        check("ovf_hi", {16'd0, result_hi}, 32'h00000000);
        check_dz("ovf_dz", 1'b0);
        step();

        // Flush in cycle 5 of a MUL: no done, results held
        op = 2'b10; op_a = 16'd3; op_b = 16'd5; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_stall", {31'd0, stall}, 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) seen++;
            step();
        end
        check("flush_nodone", seen, 0);
        check("flush_lo", {16'd0, result_lo}, 32'h00008000);
        check("flush_hi", {16'd0, result_hi}, 32'h00000000);

        // flush and start together in IDLE: nothing issued
        op = 2'b00; op_a = 16'd2; op_b = 16'd2; start = 1'b1; flush = 1'b1;
        #1;
        check("fs_stall", {31'd0, stall}, 32'd0);
        step();
        start = 1'b0;
        flush = 1'b0;
        check("fs_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) seen++;
            step();
        end
        check("fs_nodone", seen, 0);

        // Unsigned divide by zero
        do_op(2'b11, 16'h1234, 16'h0000, lat, stalls);
        check("dzu_lat", lat, DzLat);
        check("dzu_stall", stalls, DzLat);
        check("dzu_lo", {16'd0, result_lo}, 32'h0000FFFF);
        check("dzu_hi", {16'd0, result_hi}, 32'h00001234);
        check_dz("dzu_dz", 1'b1);
        step();
        check_dz("dzu_dz_clr", 1'b0);

        // Signed divide by zero
        do_op(2'b01, 16'hFFF9, 16'h0000, lat, stalls);
        check("dzs_lat", lat, DzLat);
        check("dzs_lo", {16'd0, result_lo}, 32'h0000FFFF);
        check("dzs_hi", {16'd0, result_hi}, 32'h0000FFF9);
        step();

        // Back-to-back: second issue in the DONE cycle
        do_op(2'b11, 16'd100, 16'd7, lat, stalls);
        check("b2b_first_lo", {16'd0, result_lo}, 32'h0000000E);
        do_op(2'b00, 16'h0007, 16'hFFFD, lat, stalls);
        check("b2b_lat", lat, 17);
        check("b2b_stall", stalls, 16);
        check("b2b_lo", {16'd0, result_lo}, 32'h0000FFEB);
        check("b2b_hi", {16'd0, result_hi}, 32'h0000FFFF);
        step();
        check("b2b_pulse", {31'd0, done}, 32'd0);

        // Asynchronous reset mid-RUN
        op = 2'b10; op_a = 16'd9; op_b = 16'd9; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_stall", {31'd0, stall}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_lo", {16'd0, result_lo}, 32'd0);
        check("arst_hi", {16'd0, result_hi}, 32'd0);
        #2;
        reset = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
